// File: rtl/seg7_scan_drv.sv
// Eight-digit multiplexed seven-segment scan driver for the Nexys A7 display.
// Digit words {enable, hex[3:0], dp} are latched per slot, blanked briefly, and decoded.
module seg7_scan_drv #(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);

    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    word_q, word_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    dec_cat_q, dec_cat_d;
    logic [5:0]    words [8];
    logic [2:0]    idx_nxt;

    // Active-low CA..CG pattern for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        words[0] = d1;
        words[1] = d2;
        words[2] = d3;
        words[3] = d4;
        words[4] = d5;
        words[5] = d6;
        words[6] = d7;
        words[7] = d8;
    end

    assign idx_nxt = idx_q + 3'd1;

    always_comb begin
        idx_d     = idx_q;
        cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        word_d    = word_q;
        an_d      = 8'hFF;
        dec_cat_d = 8'hFF;

        // The word is sampled only at the slot boundary and held for the whole slot.
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            idx_d  = idx_nxt;
            word_d = words[idx_nxt];
        end

        if (cnt_q >= BLANK_C && word_q[5]) begin
            an_d      = ~(8'b1 << idx_q);
            dec_cat_d = {seg7(word_q[4:1]), ~word_q[0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 3'd7;
            cnt_q     <= CNT_LAST;
            word_q    <= 6'd0;
            an_q      <= 8'hFF;
            dec_cat_q <= 8'hFF;
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            an_q      <= an_d;
            dec_cat_q <= dec_cat_d;
        end
    end

    assign an      = an_q;
    assign dec_cat = dec_cat_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Self-checking bench for seg7_scan_drv: directed phases plus random words,
// compared every cycle against a slot/frame arithmetic model of the display.
module tb_seg7_scan_drv;

    localparam int SD = 16;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] dw [8];
    logic [7:0] an;
    logic [7:0] dec_cat;

    int n_checks = 0;
    int n_errors = 0;
    int m = 0;                 // clock edges since reset release
    logic [5:0] cap [$];       // word captured for each absolute slot since release

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    seg7_scan_drv #(.SCAN_DIV(SD), .BLANK(BL)) dut (
        .clk     (clk),
        .rst     (rst),
        .d1      (dw[0]),
        .d2      (dw[1]),
        .d3      (dw[2]),
        .d4      (dw[3]),
        .d5      (dw[4]),
        .d6      (dw[5]),
        .d7      (dw[6]),
        .d8      (dw[7]),
        .an      (an),
        .dec_cat (dec_cat)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h (edge %0d)", tag, got, exp, m);
        end
    endtask

    // Pins after edge m show the display state reached at edge m-1.
    function automatic logic [15:0] model_pins();
        int s, sl, p;
        logic [5:0] w;
        if (m < 2) return 16'hFFFF;
        s  = m - 2;
        sl = s / SD;
        p  = s % SD;
        w  = cap[sl];
        if (p < BL || !w[5]) return 16'hFFFF;
        return {~(8'd1 << (sl % 8)), seg_tab[w[4:1]], ~w[0]};
    endfunction

    task automatic step();
        logic [15:0] e;
        if (!rst && (m % SD) == 0) cap.push_back(dw[(m / SD) % 8]);
        @(posedge clk);
        #1;
        if (rst) begin
            e = 16'hFFFF;
        end else begin
            m++;
            e = model_pins();
        end
        check("an", an, e[15:8]);
        check("dec_cat", dec_cat, e[7:0]);
    endtask

    function automatic int cur_digit();
        return ((m - 1) / SD) % 8;
    endfunction

    function automatic int cur_pos();
        return (m - 1) % SD;
    endfunction

    initial begin
        int lit, cnt;
        logic [7:0] last, d1dec, d8dec, lastfb;
        logic [7:0] seen [$];
        logic ok;

        for (int i = 0; i < 8; i++) dw[i] = 6'd0;
        dw[0] = 6'b1_0000_0;

        // Reset held: pins dark.
        repeat (3) step();
        rst = 1'b0; m = 0; cap.delete();
        $display("phase reset: done, checks=%0d", n_checks);

        // Single enabled digit 0: lit exactly SD-BL cycles per frame.
        step();
        lit = 0;
        repeat (8 * SD) begin
            step();
            if (an == 8'hFE && dec_cat == 8'h03) lit++;
        end
        check("t1_lit_cycles", 8'(lit), 8'(SD - BL));
        $display("phase single digit: lit=%0d", lit);

        // Hex 1..8 on all digits, dp on d8 only.
        for (int i = 0; i < 8; i++) dw[i] = {1'b1, 4'(i + 1), (i == 7)};
        repeat (8 * SD) step();
        last = an; d1dec = 8'hxx; d8dec = 8'hxx;
        repeat (8 * SD) begin
            step();
            if (an != 8'hFF && last == 8'hFF) seen.push_back(an);
            last = an;
            if (an == 8'hFE) d1dec = dec_cat;
            if (an == 8'h7F) d8dec = dec_cat;
        end
        check("t2_seen_count", 8'(seen.size()), 8'd8);
        if (seen.size() == 8)
            for (int i = 0; i < 8; i++)
                check("t2_order", seen[(i + 1) % 8], {seen[i][6:0], seen[i][7]});
        check("t2_d1_dec", d1dec, 8'h9F);
        check("t2_d8_dec", d8dec, 8'h00);
        $display("phase scan order: %0d anodes seen", seen.size());

        // All hex values on d3.
        for (int h = 0; h < 16; h++) begin
            dw[2] = {1'b1, 4'(h), 1'b0};
            lastfb = 8'hxx;
            repeat (10 * SD) begin
                step();
                if (an == 8'hFB) lastfb = dec_cat;
            end
            check($sformatf("t3_hex%0h", h), lastfb, {seg_tab[h], 1'b1});
            $display("phase hex: value %0h -> %02h", h, lastfb);
        end

        // Drop d2 enable mid-slot 1: current slot unaffected, next one blank.
        cnt = 0;
        while (!(cur_digit() == 1 && cur_pos() == 5) && cnt < 300) begin
            step();
            cnt++;
        end
        check("t4_reach_slot1", 8'(cnt < 300), 8'd1);
        dw[1][5] = 1'b0;
        lit = 0;
        repeat (SD - 5) begin
            step();
            if (an == 8'hFD) lit++;
        end
        check("t4_cur_slot_lit", 8'(lit), 8'(SD - 5));
        lit = 0;
        repeat (8 * SD) begin
            step();
            if (an == 8'hFD) lit++;
        end
        check("t4_next_slot_lit", 8'(lit), 8'd0);
        $display("phase enable toggle: done");

        // Async reset in the middle of slot 5.
        for (int i = 0; i < 8; i++) dw[i] = {1'b1, 5'($urandom)};
        repeat (8 * SD) step();
        cnt = 0;
        while (!(cur_digit() == 5 && cur_pos() == 7) && cnt < 300) begin
            step();
            cnt++;
        end
        check("t5_reach_slot5", 8'(cnt < 300), 8'd1);
        check("t5_pre_an", an, 8'hDF);
        #2;
        rst = 1'b1; m = 0; cap.delete();
        #1;
        check("t5_async_an", an, 8'hFF);
        check("t5_async_dec", dec_cat, 8'hFF);
        repeat (2) step();
        rst = 1'b0;
        step();
        cnt = 0;
        while (an == 8'hFF && cnt < 50) begin
            step();
            cnt++;
        end
        check("t5_first_lit_delay", 8'(cnt), 8'(BL + 1));
        check("t5_first_an", an, 8'hFE);
        $display("phase mid-slot reset: first lit after %0d cycles", cnt);

        // Random words for 10 frames with invariant checks.
        repeat (80 * SD) begin
            if ($urandom_range(0, 3) == 0) dw[$urandom_range(0, 7)] = 6'($urandom);
            step();
            ok = (an == 8'hFF) || ($countones(~an) == 1);
            check("t6_an_onehot", 8'(ok), 8'd1);
            if (an == 8'hFF) check("t6_dec_blank", dec_cat, 8'hFF);
        end
        $display("phase random: done, checks=%0d", n_checks);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
